// File: rtl/vtiming_gen.sv
// rtl/vtiming_gen.sv - parametrised vertical timing generator with frame-boundary timing reload
// Optional frame counter output enabled by defining VTIMING_FRAME_CNT_EN.
module vtiming_gen #(
    parameter int CNT_W         = 12,
    parameter int V_VIS_END     = 479,
    parameter int V_BEGIN_PULSE = 489,
    parameter int V_END_PULSE   = 491,
    parameter int V_COUNT_END   = 524,
    parameter int V_INIT        = 524,
    parameter bit SYNC_POL      = 1'b0,
    parameter int CHAR_H        = 16,
    parameter int ROW_W         = 6,
    parameter int FRAME_W       = 8,
    localparam int LINE_W       = $clog2(CHAR_H)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              vCountIncr,
    input  logic              cfgValid,
    output logic              cfgReady,
    input  logic [CNT_W-1:0]  cfgVisEnd,
    input  logic [CNT_W-1:0]  cfgBeginPulse,
    input  logic [CNT_W-1:0]  cfgEndPulse,
    input  logic [CNT_W-1:0]  cfgCountEnd,
    output logic              cfgErr,
    output logic [CNT_W-1:0]  vCount,
    output logic              vCountZero,
    output logic              vVisEnd,
    output logic              vBeginPulse,
    output logic              vEndPulse,
    output logic              vCountEnd,
    output logic              vActive,
    output logic              vSync,
    output logic [LINE_W-1:0] charLine,
    output logic [ROW_W-1:0]  charRow,
    output logic              frameStart
`ifdef VTIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frameCount
`endif
);

    if (CHAR_H < 2 || (CHAR_H & (CHAR_H - 1)) != 0 || FRAME_W < 1) begin : g_bad_param
        $error("vtiming_gen: CHAR_H must be a power of two >= 2 and FRAME_W >= 1");
    end

    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  vis_q, vis_d, beg_q, beg_d, endp_q, endp_d, cend_q, cend_d;
    logic [CNT_W-1:0]  p_vis_q, p_vis_d, p_beg_q, p_beg_d, p_endp_q, p_endp_d, p_cend_q, p_cend_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              sync_q, sync_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              fstart_q, fstart_d;
    logic              wrap, xfer, legal;
    logic [CNT_W-1:0]  cnt_nxt, end_p1;

    always_comb begin
        wrap    = vCountIncr && (count_q == cend_q);
        xfer    = cfgValid && !pend_q;
        legal   = (cfgVisEnd < cfgBeginPulse) && (cfgBeginPulse <= cfgEndPulse)
                  && (cfgEndPulse < cfgCountEnd);
        cnt_nxt = count_q + CNT_W'(1);
        end_p1  = endp_q + CNT_W'(1);
    end

    always_comb begin
        count_d  = count_q;
        vis_d    = vis_q;
        beg_d    = beg_q;
        endp_d   = endp_q;
        cend_d   = cend_q;
        p_vis_d  = p_vis_q;
        p_beg_d  = p_beg_q;
        p_endp_d = p_endp_q;
        p_cend_d = p_cend_q;
        pend_d   = pend_q;
        err_d    = xfer && !legal;
        sync_d   = sync_q;
        line_d   = line_q;
        row_d    = row_q;
        fstart_d = wrap;

        if (vCountIncr) begin
            if (wrap) begin
                count_d = '0;
                sync_d  = ~SYNC_POL;
                line_d  = '0;
                row_d   = '0;
            end else begin
                count_d = cnt_nxt;
                if (cnt_nxt == beg_q) begin
                    sync_d = SYNC_POL;
                end else if (cnt_nxt == end_p1) begin
                    sync_d = ~SYNC_POL;
                end
                line_d = line_q + LINE_W'(1);
                if (line_q == LINE_W'(CHAR_H - 1)) begin
                    row_d = row_q + ROW_W'(1);
                end
            end
        end

        // A set captured on this cycle's wrap sees pend_q=0 here, so it waits a full frame.
        if (wrap && pend_q) begin
            vis_d  = p_vis_q;
            beg_d  = p_beg_q;
            endp_d = p_endp_q;
            cend_d = p_cend_q;
            pend_d = 1'b0;
        end

        if (xfer && legal) begin
            p_vis_d  = cfgVisEnd;
            p_beg_d  = cfgBeginPulse;
            p_endp_d = cfgEndPulse;
            p_cend_d = cfgCountEnd;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q  <= CNT_W'(V_INIT);
            vis_q    <= CNT_W'(V_VIS_END);
            beg_q    <= CNT_W'(V_BEGIN_PULSE);
            endp_q   <= CNT_W'(V_END_PULSE);
            cend_q   <= CNT_W'(V_COUNT_END);
            p_vis_q  <= '0;
            p_beg_q  <= '0;
            p_endp_q <= '0;
            p_cend_q <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            sync_q   <= ~SYNC_POL;
            line_q   <= '0;
            row_q    <= '0;
            fstart_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            vis_q    <= vis_d;
            beg_q    <= beg_d;
            endp_q   <= endp_d;
            cend_q   <= cend_d;
            p_vis_q  <= p_vis_d;
            p_beg_q  <= p_beg_d;
            p_endp_q <= p_endp_d;
            p_cend_q <= p_cend_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            sync_q   <= sync_d;
            line_q   <= line_d;
            row_q    <= row_d;
            fstart_q <= fstart_d;
        end
    end

`ifdef VTIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            frame_q <= '0;
        end else if (wrap) begin
            frame_q <= frame_q + FRAME_W'(1);
        end
    end

    assign frameCount = frame_q;
`endif

    assign cfgReady    = !pend_q;
    assign cfgErr      = err_q;
    assign vCount      = count_q;
    assign vCountZero  = (count_q == '0);
    assign vVisEnd     = (count_q == vis_q);
    assign vBeginPulse = (count_q == beg_q);
    assign vEndPulse   = (count_q == endp_q);
    assign vCountEnd   = (count_q == cend_q);
    assign vActive     = (count_q <= vis_q);
    assign vSync       = sync_q;
    assign charLine    = line_q;
    assign charRow     = row_q;
    assign frameStart  = fstart_q;

endmodule

// File: tb/tb_vtiming_gen.sv
// tb/tb_vtiming_gen.sv - directed self-checking bench for vtiming_gen
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert (32'(obs) === 32'(exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); \
        end \
    end

module tb_vtiming_gen;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        vCountIncr = 1'b0;
    logic        cfgValid = 1'b0;
    logic        cfgReady;
    logic [11:0] cfgVisEnd = '0, cfgBeginPulse = '0, cfgEndPulse = '0, cfgCountEnd = '0;
    logic        cfgErr;
    logic [11:0] vCount;
    logic        vCountZero, vVisEnd, vBeginPulse, vEndPulse, vCountEnd, vActive, vSync;
    logic [3:0]  charLine;
    logic [5:0]  charRow;
    logic        frameStart;
`ifdef VTIMING_FRAME_CNT_EN
    logic [7:0]  frameCount;
`endif

    int errors = 0;
    int checks = 0;

    vtiming_gen dut (
        .clk(clk), .nrst(nrst), .vCountIncr(vCountIncr),
        .cfgValid(cfgValid), .cfgReady(cfgReady),
        .cfgVisEnd(cfgVisEnd), .cfgBeginPulse(cfgBeginPulse),
        .cfgEndPulse(cfgEndPulse), .cfgCountEnd(cfgCountEnd),
        .cfgErr(cfgErr), .vCount(vCount), .vCountZero(vCountZero),
        .vVisEnd(vVisEnd), .vBeginPulse(vBeginPulse), .vEndPulse(vEndPulse),
        .vCountEnd(vCountEnd), .vActive(vActive), .vSync(vSync),
        .charLine(charLine), .charRow(charRow), .frameStart(frameStart)
`ifdef VTIMING_FRAME_CNT_EN
        , .frameCount(frameCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        vCountIncr = 1'b1;
        repeat (n) tick();
        vCountIncr = 1'b0;
    endtask

    task automatic offer(input int v, input int b, input int e, input int c);
        cfgVisEnd = 12'(v); cfgBeginPulse = 12'(b); cfgEndPulse = 12'(e); cfgCountEnd = 12'(c);
        cfgValid = 1'b1;
        tick();
        cfgValid = 1'b0;
    endtask

    initial begin
        int act_cnt, sync_cnt, sync_first, sync_last, fs_cnt, cnt_bad, cl35, cr35;

        tick(); tick();
        `CHK("rst_vcount", vCount, 524)
        `CHK("rst_ready", cfgReady, 1)
        `CHK("rst_err", cfgErr, 0)
        `CHK("rst_vsync", vSync, 1)
        `CHK("rst_fstart", frameStart, 0)
        `CHK("rst_charline", charLine, 0)
        `CHK("rst_charrow", charRow, 0)
        `CHK("rst_countend", vCountEnd, 1)
        `CHK("rst_active", vActive, 0)
`ifdef VTIMING_FRAME_CNT_EN
        `CHK("rst_framecount", frameCount, 0)
`endif
        nrst = 1'b1;

        // Full default frame: first pulse wraps, then walk lines 0..524 back to 0.
        act_cnt = 0; sync_cnt = 0; sync_first = -1; sync_last = -1;
        fs_cnt = 0; cnt_bad = 0; cl35 = -1; cr35 = -1;
        vCountIncr = 1'b1;
        tick();
        `CHK("first_wrap_zero", vCountZero, 1)
        for (int ln = 0; ln <= 524; ln++) begin
            if (int'(vCount) != ln) cnt_bad++;
            if (vActive) act_cnt++;
            if (vSync == 1'b0) begin
                sync_cnt++;
                if (sync_first < 0) sync_first = ln;
                sync_last = ln;
            end
            if (frameStart) fs_cnt++;
            if (ln == 35) begin
                cl35 = int'(charLine);
                cr35 = int'(charRow);
            end
            tick();
        end
        vCountIncr = 1'b0;
        `CHK("walk_count_seq", cnt_bad, 0)
        `CHK("walk_active_lines", act_cnt, 480)
        `CHK("walk_sync_lines", sync_cnt, 3)
        `CHK("walk_sync_first", sync_first, 489)
        `CHK("walk_sync_last", sync_last, 491)
        `CHK("walk_fstart_pulses", fs_cnt, 1)
        `CHK("line35_charline", cl35, 3)
        `CHK("line35_charrow", cr35, 2)
        `CHK("wrap2_vcount", vCount, 0)
        `CHK("wrap2_fstart", frameStart, 1)
        tick();
        `CHK("fstart_one_cycle", frameStart, 0)

        // Legal set mid-frame: old timing holds until the wrap.
        adv(100);
        offer(399, 411, 412, 448);
        `CHK("legal_ready_low", cfgReady, 0)
        `CHK("legal_no_err", cfgErr, 0)
        adv(379);
        `CHK("old_visend_479", vVisEnd, 1)
        adv(45);
        `CHK("old_countend_524", vCountEnd, 1)
        `CHK("pending_ready_low", cfgReady, 0)
        adv(1);
        `CHK("apply_zero", vCountZero, 1)
        `CHK("apply_ready_high", cfgReady, 1)
        adv(399);
        `CHK("new_visend_399", vVisEnd, 1)
        `CHK("new_active_399", vActive, 1)
        adv(1);
        `CHK("new_active_400", vActive, 0)
        adv(11);
        `CHK("new_begin_411", vBeginPulse, 1)
        `CHK("new_sync_411", vSync, 0)
        adv(1);
        `CHK("new_endp_412", vEndPulse, 1)
        `CHK("new_sync_412", vSync, 0)
        adv(1);
        `CHK("new_sync_413", vSync, 1)
        adv(35);
        `CHK("new_countend_448", vCountEnd, 1)

        // Set offered on the wrap cycle waits for the following wrap.
        cfgVisEnd = 12'd479; cfgBeginPulse = 12'd489; cfgEndPulse = 12'd491; cfgCountEnd = 12'd524;
        cfgValid = 1'b1; vCountIncr = 1'b1;
        tick();
        cfgValid = 1'b0; vCountIncr = 1'b0;
        `CHK("wrapoffer_vcount", vCount, 0)
        `CHK("wrapoffer_ready_low", cfgReady, 0)
        adv(448);
        `CHK("wrapoffer_old_end448", vCountEnd, 1)
        adv(1);
        `CHK("wrapoffer_ready_high", cfgReady, 1)
        adv(448);
        `CHK("wrapoffer_new_448", vCountEnd, 0)
        adv(31);
        `CHK("wrapoffer_visend_479", vVisEnd, 1)
        adv(45);
        `CHK("wrapoffer_countend_524", vCountEnd, 1)

        // Illegal set is discarded with a single error pulse.
        offer(479, 300, 491, 524);
        `CHK("illegal_err", cfgErr, 1)
        `CHK("illegal_ready", cfgReady, 1)
        tick();
        `CHK("illegal_err_clear", cfgErr, 0)
        `CHK("illegal_timing_kept", vCountEnd, 1)
        `CHK("illegal_vcount", vCount, 524)

        // Reset with a set pending restores defaults.
        adv(6);
        offer(399, 411, 412, 448);
        `CHK("pend_before_rst", cfgReady, 0)
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        `CHK("rst2_vcount", vCount, 524)
        `CHK("rst2_ready", cfgReady, 1)
        `CHK("rst2_charline", charLine, 0)
        `CHK("rst2_vsync", vSync, 1)
        adv(1);
        adv(448);
        `CHK("rst2_default_448", vCountEnd, 0)
        adv(76);
        `CHK("rst2_default_524", vCountEnd, 1)
`ifdef VTIMING_FRAME_CNT_EN
        adv(1);
        adv(525);
        `CHK("framecount_3", frameCount, 3)
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
